// File: rtl/st7735s.sv
// Byte-serial SPI transmitter for an ST7735S panel: one command/data byte per
// strobe, shifted MSB-first in SPI mode 0 with D/C and active-low chip select.
module st7735s #(
    parameter int c_CLOCK_PER_SPI_HALF_BIT = 50
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ncommand,
    input  logic [7:0] i_data,
    input  logic       i_data_rdy,
    output logic       o_waiting,
    output logic       o_spi_clk,
    output logic       o_spi_mosi,
    output logic       o_spi_dc,
    output logic       o_spi_ss
);
    localparam int CW = $clog2(c_CLOCK_PER_SPI_HALF_BIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(c_CLOCK_PER_SPI_HALF_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BIT_LOW, S_BIT_HIGH, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          dc_q, dc_d;
    logic          waiting_q, waiting_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          ss_q, ss_d;
    logic          cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd7;
            shift_q   <= 8'h00;
            dc_q      <= 1'b0;
            waiting_q <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            ss_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            dc_q      <= dc_d;
            waiting_q <= waiting_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            ss_q      <= ss_d;
        end
    end

    // Every non-idle state lasts exactly one half-bit; the counter restarts on each phase change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_last ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        dc_d    = dc_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_data_rdy) begin
                    state_d = S_BIT_LOW;
                    idx_d   = 3'd7;
                    shift_d = i_data;
                    dc_d    = i_ncommand;
                end
            end
            S_BIT_LOW: begin
                if (cnt_last) state_d = S_BIT_HIGH;
            end
            S_BIT_HIGH: begin
                if (cnt_last) begin
                    if (idx_q != 3'd0) begin
                        idx_d   = idx_q - 3'd1;
                        state_d = S_BIT_LOW;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the pins change on the same edge as the state.
    always_comb begin
        waiting_d = (state_d == S_IDLE);
        ss_d      = (state_d == S_IDLE);
        sck_d     = (state_d == S_BIT_HIGH);
        mosi_d    = (state_d == S_IDLE) ? 1'b0 : shift_d[idx_d];
    end

    assign o_waiting  = waiting_q;
    assign o_spi_clk  = sck_q;
    assign o_spi_mosi = mosi_q;
    assign o_spi_dc   = dc_q;
    assign o_spi_ss   = ss_q;
endmodule

// File: tb/tb_st7735s.sv
// Directed bench for st7735s: an H=50 and an H=1 instance share inputs; each
// byte is decoded by sampling SCK/MOSI/D/C/SS on the falling system-clock edge.
module tb_st7735s;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ncmd = 1'b0;
    logic [7:0] data = 8'h00;
    logic       rdy = 1'b0;

    logic w50_wait, w50_sck, w50_mosi, w50_dc, w50_ss;
    logic w1_wait, w1_sck, w1_mosi, w1_dc, w1_ss;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    st7735s #(.c_CLOCK_PER_SPI_HALF_BIT(50)) dut50 (
        .i_clk(clk), .i_rst(rst), .i_ncommand(ncmd), .i_data(data), .i_data_rdy(rdy),
        .o_waiting(w50_wait), .o_spi_clk(w50_sck), .o_spi_mosi(w50_mosi),
        .o_spi_dc(w50_dc), .o_spi_ss(w50_ss));

    st7735s #(.c_CLOCK_PER_SPI_HALF_BIT(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_ncommand(ncmd), .i_data(data), .i_data_rdy(rdy),
        .o_waiting(w1_wait), .o_spi_clk(w1_sck), .o_spi_mosi(w1_mosi),
        .o_spi_dc(w1_dc), .o_spi_ss(w1_ss));

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; drives a one-cycle strobe and returns on the falling edge after it.
    task automatic strobe(input logic nc, input logic [7:0] d);
        ncmd = nc;
        data = d;
        rdy  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy = 1'b0;
    endtask

    // Samples one byte until o_waiting returns; optionally re-strobes 0xFF at busy cycle restrobe_at.
    task automatic capture(input bit sel, input logic exp_dc, input int restrobe_at,
                           output logic [7:0] rx, output int rises, output int busy,
                           output bit dc_ok, output bit ss_ok, output int hi_min, output int hi_max);
        logic s_wait, s_sck, s_mosi, s_dc, s_ss, prev;
        int hi_len;
        rx = 8'h00; rises = 0; busy = 0; dc_ok = 1'b1; ss_ok = 1'b1;
        hi_min = 1_000_000; hi_max = 0; hi_len = 0; prev = 1'b0;
        while (busy < 2000) begin
            s_wait = sel ? w1_wait : w50_wait;
            s_sck  = sel ? w1_sck  : w50_sck;
            s_mosi = sel ? w1_mosi : w50_mosi;
            s_dc   = sel ? w1_dc   : w50_dc;
            s_ss   = sel ? w1_ss   : w50_ss;
            if (s_wait) break;
            busy++;
            if (s_ss !== 1'b0) ss_ok = 1'b0;
            if (s_sck && !prev) begin
                rises++;
                rx = {rx[6:0], s_mosi};
                if (s_dc !== exp_dc) dc_ok = 1'b0;
            end
            if (s_sck) hi_len++;
            else if (prev) begin
                if (hi_len < hi_min) hi_min = hi_len;
                if (hi_len > hi_max) hi_max = hi_len;
                hi_len = 0;
            end
            prev = s_sck;
            if (busy == restrobe_at) begin
                rdy = 1'b1; data = 8'hFF; ncmd = 1'b1;
            end else begin
                rdy = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] rx, rx2;
        int rises, rises2, busy, busy2, hi_min, hi_max;
        bit dc_ok, ss_ok, bad;

        // Reset held for 10 cycles
        bad = 1'b0; rises = 0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (w50_wait !== 1'b1 || w50_ss !== 1'b1 || w50_sck !== 1'b0 ||
                w50_mosi !== 1'b0 || w50_dc !== 1'b0) bad = 1'b1;
            if (w50_sck !== 1'b0) rises++;
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (w50_wait !== 1'b1 || w50_ss !== 1'b1 || w50_sck !== 1'b0 ||
                w50_mosi !== 1'b0 || w50_dc !== 1'b0) bad = 1'b1;
            if (w50_sck !== 1'b0) rises++;
        end
        check("reset_outputs", int'(bad), 0);
        check("reset_no_sck", rises, 0);

        // H=50 command 0x95
        strobe(1'b0, 8'h95);
        check("c95_waiting_fell", int'(w50_wait), 0);
        check("c95_first_sample", int'({w50_ss, w50_sck, w50_mosi, w50_dc}), 4'b0010);
        capture(1'b0, 1'b0, -1, rx, rises, busy, dc_ok, ss_ok, hi_min, hi_max);
        check("c95_byte", int'(rx), 8'h95);
        check("c95_rises", rises, 8);
        check("c95_dc", int'(dc_ok), 1);
        check("c95_ss_low", int'(ss_ok), 1);
        check("c95_busy", busy, 850);

        // H=50 argument 0xA3
        strobe(1'b1, 8'hA3);
        capture(1'b0, 1'b1, -1, rx, rises, busy, dc_ok, ss_ok, hi_min, hi_max);
        check("a3_byte", int'(rx), 8'hA3);
        check("a3_rises", rises, 8);
        check("a3_dc", int'(dc_ok), 1);
        check("a3_hi_min", hi_min, 50);
        check("a3_hi_max", hi_max, 50);

        // Re-strobe while busy is ignored
        strobe(1'b0, 8'h11);
        capture(1'b0, 1'b0, 100, rx, rises, busy, dc_ok, ss_ok, hi_min, hi_max);
        check("c11_byte", int'(rx), 8'h11);
        check("c11_rises", rises, 8);
        check("c11_dc", int'(dc_ok), 1);
        bad = 1'b0;
        for (int i = 0; i < 900; i++) begin
            if (w50_wait !== 1'b1 || w50_ss !== 1'b1 || w50_sck !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        check("c11_no_second_byte", int'(bad), 0);

        // Reset 300 cycles into a byte
        strobe(1'b1, 8'h5A);
        for (int i = 0; i < 299; i++) @(negedge clk);
        check("midrst_busy", int'({w50_wait, w50_ss}), 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", int'({w50_wait, w50_ss, w50_sck, w50_mosi, w50_dc}), 5'b11000);
        rst = 1'b0;
        @(negedge clk);
        strobe(1'b0, 8'h2C);
        capture(1'b0, 1'b0, -1, rx, rises, busy, dc_ok, ss_ok, hi_min, hi_max);
        check("c2c_byte", int'(rx), 8'h2C);
        check("c2c_rises", rises, 8);
        check("c2c_dc", int'(dc_ok), 1);
        check("c2c_busy", busy, 850);

        // H=1 back-to-back commands 0x01 then 0x3A
        strobe(1'b0, 8'h01);
        capture(1'b1, 1'b0, -1, rx, rises, busy, dc_ok, ss_ok, hi_min, hi_max);
        strobe(1'b0, 8'h3A);
        check("h1_second_accepted", int'(w1_wait), 0);
        capture(1'b1, 1'b0, -1, rx2, rises2, busy2, bad, ss_ok, hi_min, hi_max);
        check("h1_byte0", int'(rx), 8'h01);
        check("h1_byte1", int'(rx2), 8'h3A);
        check("h1_rises", rises + rises2, 16);
        check("h1_busy0", busy, 17);
        check("h1_busy1", busy2, 17);
        check("h1_dc", int'(dc_ok && bad), 1);
        check("h1_hi_len", hi_max, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
